// File: rtl/pll_seq_pkg.sv
// ----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer and its consumers:
//   - pll_seq_state_t : sequencer FSM state encoding
//   - RETRY_W         : width of the lock-timeout retry counter
//   - DOM_*           : bit positions of the per-domain resets in dom_rst
//   - max_int         : helper used to size the shared down-counter
// ----------------------------------------------------------------------------
package pll_seq_pkg;

    localparam int RETRY_W = 4;

    // Domain reset bit positions
    localparam int DOM_30M  = 0;
    localparam int DOM_48M  = 1;
    localparam int DOM_3M58 = 2;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } pll_seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// ----------------------------------------------------------------------------
// sync2
// Two-flop single-bit synchronizer with synchronous active-high clear.
// Reusable by any consumer that needs to bring an asynchronous level into
// its own clock domain.
// Ports:
//   clk_i : destination clock
//   rst_i : synchronous active-high clear of both stages
//   d_i   : asynchronous input level
//   q_o   : synchronized level, 2 cycles after d_i settles
// ----------------------------------------------------------------------------
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
// Brings up the three-output system PLL: holds the PLL in reset, waits for a
// stable lock, then releases the per-domain resets one at a time. Recovers
// from lock loss (full PLL re-reset) and from soft_rst (domain re-release
// only, PLL untouched).
//
// Build option: define PLL_SEQ_WATCHDOG_EN to enable the WAIT_LOCK timeout
// that re-pulses pll_rst and counts retries in retry_cnt. Without it the
// sequencer waits for lock indefinitely and retry_cnt is tied to zero.
//
// Ports (all in the refclk domain, all outputs registered):
//   refclk    : reference clock, the only clock
//   rst       : synchronous active-high reset
//   locked    : PLL lock, asynchronous; synchronized internally
//   soft_rst  : single-cycle request to re-release the domains
//   pll_rst   : PLL reset
//   dom_rst   : per-domain resets, active-high (bit 0 = 30 MHz,
//               bit 1 = 48 MHz, bit 2 = 3.58 MHz)
//   ready     : all domains released
//   retry_cnt : saturating count of lock-timeout retries
// ----------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 1024,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int RELEASE_GAP    = 64,
    parameter int NUM_DOMAINS    = 3
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   locked,
    input  logic                   soft_rst,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   ready,
    output logic [RETRY_W-1:0]     retry_cnt
);

    localparam int CNT_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE),
                                     max_int(LOCK_TIMEOUT, RELEASE_GAP));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // Counter reload values: every phase counts down to zero, so N cycles
    // are loaded as N-1.
    localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_STABLE = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] LD_TMO    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(RELEASE_GAP - 1);

    logic lock_s;

    sync2 u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (locked),
        .q_o   (lock_s)
    );

    pll_seq_state_t         state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;   // next domain to release
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   ready_q,   ready_d;
`ifdef PLL_SEQ_WATCHDOG_EN
    logic [RETRY_W-1:0]     retry_q,   retry_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pll_rst_d = pll_rst_q;
        dom_rst_d = dom_rst_q;
        ready_d   = ready_q;
`ifdef PLL_SEQ_WATCHDOG_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            ST_PLL_RESET: begin
                pll_rst_d = 1'b1;
                dom_rst_d = '1;
                ready_d   = 1'b0;
                if (cnt_q == '0) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = LD_TMO;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock has priority over an expiring timeout.
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = LD_STABLE;
                end
`ifdef PLL_SEQ_WATCHDOG_EN
                else if (cnt_q == '0) begin
                    state_d   = ST_PLL_RESET;
                    cnt_d     = LD_RST;
                    pll_rst_d = 1'b1;
                    if (retry_q != '1)
                        retry_d = retry_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = LD_TMO;
                end else if (cnt_q == '0) begin
                    // First domain drops on the same edge we leave STABLE so
                    // lock_s-rise to dom_rst[0]-fall is LOCK_STABLE+1 cycles.
                    dom_rst_d[DOM_30M] = 1'b0;
                    cnt_d              = LD_GAP;
                    if (NUM_DOMAINS == 1) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!lock_s) begin
                    // Lock loss beats soft_rst and forces a full PLL re-reset.
                    state_d   = ST_PLL_RESET;
                    cnt_d     = LD_RST;
                    pll_rst_d = 1'b1;
                    dom_rst_d = '1;
                    ready_d   = 1'b0;
                end else if (soft_rst) begin
                    // Re-release from domain 0; the first release waits one
                    // full gap so every domain sees a reset pulse.
                    state_d   = ST_RELEASE;
                    idx_d     = '0;
                    cnt_d     = LD_GAP;
                    dom_rst_d = '1;
                    ready_d   = 1'b0;
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == '0) begin
                        dom_rst_d[idx_q] = 1'b0;
                        cnt_d            = LD_GAP;
                        if (int'(idx_q) == NUM_DOMAINS - 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_PLL_RESET;
                cnt_d     = LD_RST;
                pll_rst_d = 1'b1;
                dom_rst_d = '1;
                ready_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RESET;
            cnt_q     <= LD_RST;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_rst_q <= '1;
            ready_q   <= 1'b0;
`ifdef PLL_SEQ_WATCHDOG_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pll_rst_q <= pll_rst_d;
            dom_rst_q <= dom_rst_d;
            ready_q   <= ready_d;
`ifdef PLL_SEQ_WATCHDOG_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign pll_rst = pll_rst_q;
    assign dom_rst = dom_rst_q;
    assign ready   = ready_q;
`ifdef PLL_SEQ_WATCHDOG_EN
    assign retry_cnt = retry_q;
`else
    assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with PLL_RST_CYCLES=4,
// LOCK_STABLE=8, RELEASE_GAP=5, LOCK_TIMEOUT=50. Cycle n means "just after
// the n-th rising edge with rst low"; inputs are changed 1 ns after an edge
// and are therefore sampled on the following edge.
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       soft_rst;
    logic       pll_rst;
    logic [2:0] dom_rst;
    logic       ready;
    logic [3:0] retry_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = -1;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_STABLE    (8),
        .LOCK_TIMEOUT   (50),
        .RELEASE_GAP    (5),
        .NUM_DOMAINS    (3)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .soft_rst  (soft_rst),
        .pll_rst   (pll_rst),
        .dom_rst   (dom_rst),
        .ready     (ready),
        .retry_cnt (retry_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = -1;
    endtask

    int pulses;

    initial begin
        rst = 1'b1; locked = 1'b0; soft_rst = 1'b0;
        tick();
        tick();
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_dom_rst", 32'(dom_rst), 32'd7);
        chk("rst_ready",   32'(ready), 32'd0);
        chk("rst_retry",   32'(retry_cnt), 32'd0);

        // ---- clean bring-up: locked rises before edge 10 ----
        rst = 1'b0; cyc = -1;
        go(2);  chk("up_pll_hi", 32'(pll_rst), 32'd1);
        go(3);  chk("up_pll_lo", 32'(pll_rst), 32'd0);
        go(9);  locked = 1'b1;
        go(19); chk("up_dom_111", 32'(dom_rst), 32'd7);
        go(20); chk("up_dom_110", 32'(dom_rst), 32'd6);
        go(24); chk("up_dom_110b", 32'(dom_rst), 32'd6);
        go(25); chk("up_dom_100", 32'(dom_rst), 32'd4);
                chk("up_rdy_lo", 32'(ready), 32'd0);
        go(29); chk("up_dom_100b", 32'(dom_rst), 32'd4);
        go(30); chk("up_dom_000", 32'(dom_rst), 32'd0);
                chk("up_rdy_hi", 32'(ready), 32'd1);

        // ---- glitchy lock: high 5, low 1, high ----
        locked = 1'b0;
        do_reset();
        go(9);  locked = 1'b1;
        go(14); locked = 1'b0;
        go(15); locked = 1'b1;
        go(20); chk("gl_hold", 32'(dom_rst), 32'd7);
        go(25); chk("gl_hold2", 32'(dom_rst), 32'd7);
        go(26); chk("gl_rel0", 32'(dom_rst), 32'd6);
        go(36); chk("gl_run_dom", 32'(dom_rst), 32'd0);
                chk("gl_run_rdy", 32'(ready), 32'd1);

        // ---- lock loss in RUN: locked low for one cycle ----
        go(40); locked = 1'b0;
        go(41); locked = 1'b1;
        go(42); chk("ll_still_run", 32'(dom_rst), 32'd0);
        go(43); chk("ll_dom", 32'(dom_rst), 32'd7);
                chk("ll_rdy", 32'(ready), 32'd0);
                chk("ll_pll", 32'(pll_rst), 32'd1);
        go(46); chk("ll_pll_hold", 32'(pll_rst), 32'd1);
        go(47); chk("ll_pll_rel", 32'(pll_rst), 32'd0);
        go(55); chk("ll_dom_hold", 32'(dom_rst), 32'd7);
        go(56); chk("ll_rel0", 32'(dom_rst), 32'd6);
        go(61); chk("ll_rel1", 32'(dom_rst), 32'd4);
        go(66); chk("ll_rel2", 32'(dom_rst), 32'd0);
                chk("ll_rdy_hi", 32'(ready), 32'd1);
                chk("ll_no_retry", 32'(retry_cnt), 32'd0);

        // ---- soft_rst in RUN ----
        go(69); soft_rst = 1'b1;
        go(70); soft_rst = 1'b0;
                chk("sr_dom", 32'(dom_rst), 32'd7);
                chk("sr_rdy", 32'(ready), 32'd0);
                chk("sr_pll", 32'(pll_rst), 32'd0);
        go(74); chk("sr_hold", 32'(dom_rst), 32'd7);
        go(75); chk("sr_rel0", 32'(dom_rst), 32'd6);
                chk("sr_pll2", 32'(pll_rst), 32'd0);
        go(80); chk("sr_rel1", 32'(dom_rst), 32'd4);
        go(85); chk("sr_rel2", 32'(dom_rst), 32'd0);
                chk("sr_rdy_hi", 32'(ready), 32'd1);

        // ---- lock loss and soft_rst seen on the same edge (91) ----
        go(88); locked = 1'b0;
        go(90); soft_rst = 1'b1;
        go(91); soft_rst = 1'b0;
                chk("sim_pll", 32'(pll_rst), 32'd1);
                chk("sim_dom", 32'(dom_rst), 32'd7);
                chk("sim_rdy", 32'(ready), 32'd0);
        go(94); chk("sim_pll_hold", 32'(pll_rst), 32'd1);
        go(95); chk("sim_pll_rel", 32'(pll_rst), 32'd0);

        // ---- locked held low: timeout behaviour depends on the build ----
`ifdef PLL_SEQ_WATCHDOG_EN
        go(144); chk("to_pre_pll", 32'(pll_rst), 32'd0);
                 chk("to_pre_cnt", 32'(retry_cnt), 32'd0);
        go(145); chk("to1_pll", 32'(pll_rst), 32'd1);
                 chk("to1_cnt", 32'(retry_cnt), 32'd1);
        go(148); chk("to1_pll_hold", 32'(pll_rst), 32'd1);
        go(149); chk("to1_pll_rel", 32'(pll_rst), 32'd0);
        go(199); chk("to2_cnt", 32'(retry_cnt), 32'd2);
                 chk("to2_pll", 32'(pll_rst), 32'd1);
        go(253); chk("to3_cnt", 32'(retry_cnt), 32'd3);
        go(900); chk("to14_cnt", 32'(retry_cnt), 32'd14);
        go(901); chk("to15_cnt", 32'(retry_cnt), 32'd15);
        go(955); chk("to_sat_cnt", 32'(retry_cnt), 32'd15);
                 chk("to_sat_pll", 32'(pll_rst), 32'd1);
`else
        pulses = 0;
        while (cyc < 1099) begin
            tick();
            if (pll_rst) pulses++;
        end
        chk("nowd_pulses", 32'(pulses), 32'd0);
        chk("nowd_retry", 32'(retry_cnt), 32'd0);
        chk("nowd_dom", 32'(dom_rst), 32'd7);
`endif

        // ---- rst mid-operation ----
        go(1099); rst = 1'b1;
        go(1100); rst = 1'b0;
                  chk("mid_rst_pll", 32'(pll_rst), 32'd1);
                  chk("mid_rst_dom", 32'(dom_rst), 32'd7);
                  chk("mid_rst_rdy", 32'(ready), 32'd0);
                  chk("mid_rst_retry", 32'(retry_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences bring-up of the three-output system PLL (30 MHz, 48 MHz, 3.58 MHz). It holds the PLL in reset for a fixed time, waits for a stable `locked`, then releases per-clock-domain resets one at a time in a fixed order. It recovers from lock loss and lock timeout automatically, and sits in the reference-clock domain between the PLL wrapper and the core reset tree.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt.
- `LOCK_STABLE`, 1024: consecutive synchronized-`locked` cycles required before releasing domains.
- `LOCK_TIMEOUT`, 500000: cycles allowed in WAIT_LOCK before retrying (10 ms at 50 MHz).
- `RELEASE_GAP`, 64: cycles between successive domain releases.
- `NUM_DOMAINS`, 3: number of domain resets.

Ports:
- `refclk`, in, 1: 50 MHz reference clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `locked`, in, 1: PLL lock, asynchronous to `refclk`.
- `soft_rst`, in, 1: single-cycle request to re-reset the domains without resetting the PLL.
- `pll_rst`, out, 1: drives the PLL `rst`.
- `dom_rst`, out, NUM_DOMAINS: per-domain reset, active-high. Bit 0 maps to 30 MHz, bit 1 to 48 MHz, bit 2 to 3.58 MHz. Each consumer synchronizes its own bit.
- `ready`, out, 1: high when all domains are released.
- `retry_cnt`, out, 4: saturating count of lock-timeout retries.

## Operation
- `locked` passes through a 2-FF synchronizer (`lock_s`). All decisions use `lock_s`.
- The FSM has five states: PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN. One shared down-counter `cnt`, sized `$clog2` of the largest parameter.
- **PLL_RESET:** `pll_rst`=1 and `dom_rst`=all ones. Stays for PLL_RST_CYCLES cycles, then goes to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0.
  - `lock_s`=1: go to STABLE with `cnt`=LOCK_STABLE-1.
  - `cnt` expires: go to PLL_RESET and increment `retry_cnt` (saturates at 15).
- **STABLE:**
  - `lock_s`=0: return to WAIT_LOCK; the timeout counter restarts.
  - LOCK_STABLE consecutive high cycles: go to RELEASE with index `idx`=0.
- **RELEASE:** clears `dom_rst[idx]`, waits RELEASE_GAP cycles, then increments `idx`. After the last domain is cleared it goes to RUN without waiting a further gap.
- **RUN:** `ready`=1.
- **Lock loss:** `lock_s`=0 in RELEASE or RUN sets `dom_rst`=all ones, `ready`=0 and goes to PLL_RESET. `retry_cnt` does not increment.
- **soft_rst:** in RELEASE or RUN, sets `dom_rst`=all ones, `ready`=0 and restarts RELEASE at `idx`=0. `pll_rst` stays low. `soft_rst` in any other state is ignored.
- **Simultaneous lock loss and soft_rst:** lock loss wins.
- `retry_cnt` is cleared only by `rst`.

## Timing
- **Reset values:** `pll_rst`=1, `dom_rst`=all ones, `ready`=0, `retry_cnt`=0, state=PLL_RESET, `cnt`=PLL_RST_CYCLES-1, synchronizer cleared.
- **`rst` mid-operation:** the cycle after `rst` is sampled high, all outputs hold their reset values and the sequence restarts from PLL_RESET.
- **Latency:** a `locked` edge reaches `lock_s` after 2 cycles. From `lock_s` rising to `dom_rst[0]` falling takes LOCK_STABLE+1 cycles.
- **Release spacing:** `dom_rst[k]` falls RELEASE_GAP cycles after `dom_rst[k-1]`. `ready` rises the same cycle `dom_rst[NUM_DOMAINS-1]` falls.
- **Lock-loss response:** `dom_rst` re-asserts 1 cycle after `lock_s` falls (3 cycles after `locked` falls).
- All outputs are registered.

## Configuration
- Macro `PLL_SEQ_WATCHDOG_EN`.
- **Defined:** LOCK_TIMEOUT retry logic and `retry_cnt` are active as above.
- **Undefined:** WAIT_LOCK waits indefinitely and `retry_cnt` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `pll_seq_pkg`:
  - state enum type `pll_seq_state_t`;
  - `RETRY_W`=4;
  - domain index constants `DOM_30M`=0, `DOM_48M`=1, `DOM_3M58`=2.
- One sub-module: `sync2`, the 2-FF bit synchronizer for `locked`, reusable by the domain consumers.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_STABLE=8, RELEASE_GAP=5, LOCK_TIMEOUT=50.
- **Clean bring-up:** `rst` 1→0, `locked` rises at cycle 10.
  - `pll_rst` is low from cycle 4.
  - `dom_rst` goes 111→110→100→000 at 5-cycle spacing.
  - `ready`=1 coincides with 000.
- **Glitchy lock:** `locked` high 5 cycles, low 1, then high. No domain is released until 8 consecutive `lock_s` cycles.
- **Timeout:** `locked` held low.
  - `pll_rst` re-pulses for 4 cycles every 54 cycles.
  - `retry_cnt` counts 1, 2, 3 and saturates at 15 after 15+ attempts.
- **Lock loss in RUN:** drop `locked` for 1 cycle. `dom_rst`=111 and `ready`=0 within 3 cycles, `pll_rst` pulses, then a full re-sequence.
- **soft_rst in RUN:** `dom_rst`=111 the next cycle, `pll_rst` stays 0, re-release at 5-cycle spacing.
- **Simultaneous events and build variant:**
  - `soft_rst` and `locked` fall on the same cycle: expect the PLL_RESET path.
  - With `PLL_SEQ_WATCHDOG_EN` undefined and `locked` low for 1000 cycles: no `pll_rst` re-pulse and `retry_cnt`=0.
